mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (CPU fetch / host access) round-robin arbiter in front of a single-ported memory.
// Define MEM_ARBITER_READBACK_EN to verify each host write by reading the location back.
module mem_arbiter #(
  parameter int unsigned WORD     = 1,
  parameter int unsigned SIZE_LOG = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic [SIZE_LOG-1:0] cpu_addr,
  output logic                cpu_ack,
  output logic [WORD-1:0]     cpu_rdata,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [SIZE_LOG-1:0] host_addr,
  input  logic [WORD-1:0]     host_wdata,
  output logic                host_ack,
  output logic [WORD-1:0]     host_rdata,
  output logic                host_err,
  output logic                busy,
  output logic                mem_read,
  output logic                mem_write,
  output logic [SIZE_LOG-1:0] mem_address,
  output logic [WORD-1:0]     mem_data_in,
  input  logic [WORD-1:0]     mem_data_out
);

`ifdef MEM_ARBITER_READBACK_EN
  typedef enum logic [2:0] {
    StIdle, StSetup, StStrobe, StCapture, StDone, StGap, StRstrobe, StRcapture
  } state_e;
`else
  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StCapture, StDone} state_e;
`endif

  state_e                state_q, state_d;
  logic                  grant_host_q, grant_host_d;
  logic                  last_host_q, last_host_d;
  logic                  we_q, we_d;
  logic [SIZE_LOG-1:0]   addr_q, addr_d;
  logic [WORD-1:0]       wdata_q, wdata_d;
  logic [WORD-1:0]       cpu_rdata_q, cpu_rdata_d;
  logic [WORD-1:0]       host_rdata_q, host_rdata_d;
  logic                  pick_host;
  logic                  strobe_phase;
  logic                  rb_phase;
  logic                  done;

  // Host wins if it is alone, or if both ask and the CPU was granted last.
  assign pick_host = host_req & (~cpu_req | ~last_host_q);

`ifdef MEM_ARBITER_READBACK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    grant_host_d = grant_host_q;
    last_host_d  = last_host_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
`ifdef MEM_ARBITER_READBACK_EN
    err_d        = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cpu_req || host_req) begin
          grant_host_d = pick_host;
          last_host_d  = pick_host;
          we_d         = pick_host & host_we;
          addr_d       = pick_host ? host_addr : cpu_addr;
          wdata_d      = pick_host ? host_wdata : '0;
`ifdef MEM_ARBITER_READBACK_EN
          err_d        = 1'b0;
`endif
          state_d      = StSetup;
        end
      end
      StSetup:  state_d = StStrobe;
      StStrobe: state_d = StCapture;
      StCapture: begin
        if (!we_q) begin
          if (grant_host_q) host_rdata_d = mem_data_out;
          else              cpu_rdata_d  = mem_data_out;
          state_d = StDone;
        end else begin
`ifdef MEM_ARBITER_READBACK_EN
          state_d = StGap;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef MEM_ARBITER_READBACK_EN
      StGap:     state_d = StRstrobe;
      StRstrobe: state_d = StRcapture;
      StRcapture: begin
        host_rdata_d = mem_data_out;
        err_d        = (mem_data_out != wdata_q);
        state_d      = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_host_q <= 1'b0;
      last_host_q  <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
`ifdef MEM_ARBITER_READBACK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_host_q <= grant_host_d;
      last_host_q  <= last_host_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
`ifdef MEM_ARBITER_READBACK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign strobe_phase = (state_q == StStrobe) || (state_q == StCapture);
  assign done         = (state_q == StDone);
`ifdef MEM_ARBITER_READBACK_EN
  assign rb_phase = (state_q == StRstrobe) || (state_q == StRcapture);
  assign host_err = err_q & done & grant_host_q;
`else
  assign rb_phase = 1'b0;
  assign host_err = 1'b0;
`endif

  // Address and write data come straight from the grant-time latches, so they are
  // stable for the whole access and read as zero under reset.
  assign mem_read    = (strobe_phase & ~we_q) | rb_phase;
  assign mem_write   = strobe_phase & we_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign cpu_ack     = done & ~grant_host_q;
  assign host_ack    = done & grant_host_q;
  assign busy        = (state_q != StIdle);
  assign cpu_rdata   = cpu_rdata_q;
  assign host_rdata  = host_rdata_q;

endmodule
